// File: rtl/wb_reg_file_pkg.sv
// rtl/wb_reg_file_pkg.sv - shared types and defaults for the write-back register file
// Contents:
//   wb_state_e    : FSM state (CLEAR while the zeroing sweep runs, READY afterwards)
//   DEF_REGS      : default number of architectural registers
//   DEF_WIDTH     : default register width in bits
//   IDX_W         : width of register indices on the bus
//   idx_in_range  : true when an index names a real, writable register (not 0, below REGS)
package wb_reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } wb_state_e;

  localparam int DEF_REGS  = 32;
  localparam int DEF_WIDTH = 32;
  localparam int IDX_W     = 8;

  // Register 0 is hard-wired to zero, so it never counts as a real target.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int regs);
    return (idx != '0) && (32'(idx) < 32'(regs));
  endfunction

endpackage

// File: rtl/wb_reg_file_if.sv
// rtl/wb_reg_file_if.sv - bus bundle between MemWB/decode and the register file
// Signals:
//   regs_data_in   : write-back data
//   regs_wr_id_in  : destination register index
//   regs_write_in  : write enable qualifying data and index
//   rs1_id_in      : read port 1 index
//   rs2_id_in      : read port 2 index
//   rs1_data_out   : read port 1 data (combinational)
//   rs2_data_out   : read port 2 data (combinational)
//   busy_out       : high while the post-reset clear sweep runs
// Modports: master (pipeline side), slave (register file side).
interface wb_reg_file_if
  import wb_reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] regs_data_in;
  logic [IDX_W-1:0] regs_wr_id_in;
  logic             regs_write_in;
  logic [IDX_W-1:0] rs1_id_in;
  logic [IDX_W-1:0] rs2_id_in;
  logic [WIDTH-1:0] rs1_data_out;
  logic [WIDTH-1:0] rs2_data_out;
  logic             busy_out;

  modport master (
    output regs_data_in, regs_wr_id_in, regs_write_in, rs1_id_in, rs2_id_in,
    input  rs1_data_out, rs2_data_out, busy_out
  );

  modport slave (
    input  regs_data_in, regs_wr_id_in, regs_write_in, rs1_id_in, rs2_id_in,
    output rs1_data_out, rs2_data_out, busy_out
  );

endinterface

// File: rtl/wb_reg_file_rdport.sv
// rtl/wb_reg_file_rdport.sv - one combinational read port of the register file
// Optional feature: WB_REG_FILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Ports:
//   busy_i     : sweep in progress; forces the port to read zero
//   rd_id_i    : read index
//   byp_en_i   : (bypass builds only) qualified write happening this cycle
//   byp_id_i   : (bypass builds only) index being written
//   byp_data_i : (bypass builds only) data being written
//   regs_i     : register array contents
//   rd_data_o  : read data; zero for index 0 or out-of-range indices
module wb_reg_file_rdport
  import wb_reg_file_pkg::*;
#(
  parameter int REGS  = DEF_REGS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             busy_i,
  input  logic [IDX_W-1:0] rd_id_i,
`ifdef WB_REG_FILE_BYPASS_EN
  input  logic             byp_en_i,
  input  logic [IDX_W-1:0] byp_id_i,
  input  logic [WIDTH-1:0] byp_data_i,
`endif
  input  logic [WIDTH-1:0] regs_i [REGS],
  output logic [WIDTH-1:0] rd_data_o
);

  always_comb begin
    rd_data_o = '0;
    if (!busy_i) begin
      // Start at 1: register 0 always reads zero; no match leaves zero for out-of-range.
      for (int i = 1; i < REGS; i++) begin
        if (rd_id_i == IDX_W'(i)) begin
          rd_data_o = regs_i[i];
        end
      end
`ifdef WB_REG_FILE_BYPASS_EN
      // byp_en_i is already limited to valid nonzero indices in READY.
      if (byp_en_i && (byp_id_i == rd_id_i)) begin
        rd_data_o = byp_data_i;
      end
`endif
    end
  end

endmodule

// File: rtl/wb_reg_file.sv
// rtl/wb_reg_file.sv - write-back register file with post-reset zeroing sweep
// Optional feature: WB_REG_FILE_BYPASS_EN forwards a same-cycle write to matching read ports.
// Parameters: ID (informational), REGS (register count, at most 256), WIDTH (data width).
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : wb_reg_file_if slave (write port, two read ports, busy_out)
module wb_reg_file
  import wb_reg_file_pkg::*;
#(
  parameter int ID    = 0,
  parameter int REGS  = DEF_REGS,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  wb_reg_file_if.slave  bus
);

  localparam int CW = (REGS > 1) ? $clog2(REGS) : 1;

  wb_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [REGS];
  logic             wr_ok;
  logic             busy;

  assign busy  = (state_q == CLEAR);
  assign wr_ok = bus.regs_write_in && !busy && idx_in_range(bus.regs_wr_id_in, REGS);

  assign bus.busy_out = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(REGS - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REGS; i++) begin
      if (busy) begin
        if (cnt_q == CW'(i)) begin
          regs_q[i] <= '0;
        end
      end else if (wr_ok && (bus.regs_wr_id_in == IDX_W'(i))) begin
        regs_q[i] <= bus.regs_data_in;
      end
    end
  end

  wb_reg_file_rdport #(
    .REGS  (REGS),
    .WIDTH (WIDTH)
  ) u_rd1 (
    .busy_i     (busy),
    .rd_id_i    (bus.rs1_id_in),
`ifdef WB_REG_FILE_BYPASS_EN
    .byp_en_i   (wr_ok),
    .byp_id_i   (bus.regs_wr_id_in),
    .byp_data_i (bus.regs_data_in),
`endif
    .regs_i     (regs_q),
    .rd_data_o  (bus.rs1_data_out)
  );

  wb_reg_file_rdport #(
    .REGS  (REGS),
    .WIDTH (WIDTH)
  ) u_rd2 (
    .busy_i     (busy),
    .rd_id_i    (bus.rs2_id_in),
`ifdef WB_REG_FILE_BYPASS_EN
    .byp_en_i   (wr_ok),
    .byp_id_i   (bus.regs_wr_id_in),
    .byp_data_i (bus.regs_data_in),
`endif
    .regs_i     (regs_q),
    .rd_data_o  (bus.rs2_data_out)
  );

endmodule

// File: tb/tb_wb_reg_file.sv
// tb/tb_wb_reg_file.sv - directed self-checking bench for wb_reg_file (REGS=32, WIDTH=32)
// Expectations follow WB_REG_FILE_BYPASS_EN when the macro is defined for the build.
module tb_wb_reg_file;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_regs [32];
  int   busy_cycles;

`ifdef WB_REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_reg_file_if #(.WIDTH(32)) bus ();

  wb_reg_file #(
    .ID    (0),
    .REGS  (32),
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles with busy_out high, bounded so a stuck FSM cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy_out === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_id_in = 8'(i);
      bus.rs2_id_in = 8'(31 - i);
      #1;
      check_val($sformatf("%s_rs1_r%0d", tag, i), bus.rs1_data_out, exp_regs[i]);
      check_val($sformatf("%s_rs2_r%0d", tag, 31 - i), bus.rs2_data_out, exp_regs[31 - i]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    reset = 1'b0;
    bus.regs_data_in  = 32'h0;
    bus.regs_wr_id_in = 8'd0;
    bus.regs_write_in = 1'b0;
    bus.rs1_id_in     = 8'd5;
    bus.rs2_id_in     = 8'd7;

    tick();
    tick();
    check_val("reset_busy", {31'b0, bus.busy_out}, 32'h1);
    check_val("reset_rs1", bus.rs1_data_out, 32'h0);

    // First sweep after release.
    reset = 1'b1;
    #1;
    check_val("sweep_rs1_zero", bus.rs1_data_out, 32'h0);
    count_busy(busy_cycles);
    check_val("sweep1_len", 32'(busy_cycles), 32'd32);
    check_val("ready_busy_low", {31'b0, bus.busy_out}, 32'h0);
    check_all_regs("post_sweep");

    // Write id 5, read next cycle.
    bus.rs1_id_in = 8'd5;
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd5;
    bus.regs_data_in  = 32'hDEADBEEF;
    #1;
    check_val("wr5_same_cycle", bus.rs1_data_out, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    bus.regs_write_in = 1'b0;
    #1;
    check_val("wr5_next_cycle", bus.rs1_data_out, 32'hDEADBEEF);
    exp_regs[5] = 32'hDEADBEEF;

    // Write to id 0 is dropped and never bypassed.
    bus.rs1_id_in = 8'd0;
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd0;
    bus.regs_data_in  = 32'h1234;
    #1;
    check_val("wr0_same_cycle", bus.rs1_data_out, 32'h0);
    tick();
    bus.regs_write_in = 1'b0;
    #1;
    check_val("wr0_read", bus.rs1_data_out, 32'h0);

    // Write id 7 with both ports on 7.
    bus.rs1_id_in = 8'd7;
    bus.rs2_id_in = 8'd7;
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd7;
    bus.regs_data_in  = 32'hA5A5A5A5;
    #1;
    check_val("wr7_rs1_same", bus.rs1_data_out, BYP ? 32'hA5A5A5A5 : 32'h0);
    check_val("wr7_rs2_same", bus.rs2_data_out, BYP ? 32'hA5A5A5A5 : 32'h0);
    tick();
    bus.regs_write_in = 1'b0;
    #1;
    check_val("wr7_rs1_next", bus.rs1_data_out, 32'hA5A5A5A5);
    check_val("wr7_rs2_next", bus.rs2_data_out, 32'hA5A5A5A5);
    exp_regs[7] = 32'hA5A5A5A5;

    // Back-to-back writes to id 9: last value wins.
    bus.rs1_id_in = 8'd9;
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd9;
    bus.regs_data_in  = 32'h11111111;
    tick();
    bus.regs_data_in  = 32'h22222222;
    tick();
    bus.regs_write_in = 1'b0;
    #1;
    check_val("wr9_last", bus.rs1_data_out, 32'h22222222);
    exp_regs[9] = 32'h22222222;

    // Write id 31 (top boundary) lands.
    bus.rs1_id_in = 8'd31;
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd31;
    bus.regs_data_in  = 32'h0F0F0001;
    tick();
    bus.regs_write_in = 1'b0;
    #1;
    check_val("wr31_read", bus.rs1_data_out, 32'h0F0F0001);
    exp_regs[31] = 32'h0F0F0001;

    // Out-of-range write id 40: dropped, not bypassed, no aliasing onto id 8.
    bus.rs1_id_in = 8'd40;
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd40;
    bus.regs_data_in  = 32'hFFFFFFFF;
    #1;
    check_val("wr40_same_cycle", bus.rs1_data_out, 32'h0);
    tick();
    bus.regs_write_in = 1'b0;
    #1;
    check_val("wr40_read", bus.rs1_data_out, 32'h0);
    check_all_regs("after_wr40");

    // Reset in READY, then again at sweep cycle 10.
    reset = 1'b0;
    #1;
    check_val("ready_reset_busy", {31'b0, bus.busy_out}, 32'h1);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("mid_sweep_busy", {31'b0, bus.busy_out}, 32'h1);
    reset = 1'b0;
    #1;
    check_val("mid_reset_busy", {31'b0, bus.busy_out}, 32'h1);
    tick();
    reset = 1'b1;
    // Hold a write to id 3 across the whole sweep; it must be ignored.
    bus.regs_write_in = 1'b1;
    bus.regs_wr_id_in = 8'd3;
    bus.regs_data_in  = 32'h55;
    count_busy(busy_cycles);
    bus.regs_write_in = 1'b0;
    check_val("sweep2_len", 32'(busy_cycles), 32'd32);
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    bus.rs1_id_in = 8'd3;
    #1;
    check_val("sweep_write_dropped", bus.rs1_data_out, 32'h0);
    check_all_regs("after_resweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
